// File: rtl/mips_multicycle_core.sv
// Multi-cycle 32-bit MIPS core that fetches and executes over one shared memory port.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   mem_req/mem_we  registered access request and direction, held until mem_ready
//   mem_addr        registered word-aligned byte address (low ADDR_W bits)
//   mem_wdata       registered store data
//   mem_rdata       read data, sampled on the cycle mem_req & mem_ready
//   mem_ready       access completion strobe, ignored while mem_req is low
//   pc              program counter
//   retired         completed-instruction count, wraps
//   illegal         sticky flag for an unsupported opcode or funct
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [CNT_W-1:0]  retired,
    output logic              illegal
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDI, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t      state, next_state;
    logic [31:0] ir, a, b, alu_out, mdr;
    logic [31:0] rf [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sign_imm, alu_sum, alu_r, pc_d, addr_d;
    logic        funct_ok, req_d, we_d, ld_addr, ld_wdata, retire;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sign_imm = {{16{ir[15]}}, ir[15:0]};
    assign alu_sum  = a + sign_imm;

    // R-type ALU; funct_ok flags the supported subset
    always_comb begin
        alu_r    = '0;
        funct_ok = 1'b1;
        case (funct)
            6'h20:   alu_r = a + b;
            6'h22:   alu_r = a - b;
            6'h24:   alu_r = a & b;
            6'h25:   alu_r = a | b;
            6'h2A:   alu_r = {31'd0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next state, next PC and next values of the registered memory port
    always_comb begin
        next_state = state;
        req_d      = 1'b0;
        we_d       = 1'b0;
        ld_addr    = 1'b0;
        addr_d     = pc;
        ld_wdata   = 1'b0;
        pc_d       = pc;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                // Right after reset no request is out yet: raise it first.
                if (!mem_req) begin
                    req_d   = 1'b1;
                    ld_addr = 1'b1;
                    addr_d  = pc;
                end else if (mem_ready) begin
                    next_state = S_DECODE;
                    pc_d       = pc + 32'd4;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_RTYPE:       next_state = S_EXEC;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:        next_state = S_ADDI;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_HALT;
                endcase
            end
            S_MEMADR: begin
                req_d   = 1'b1;
                ld_addr = 1'b1;
                addr_d  = alu_sum & ~32'd3;
                if (opcode == OP_SW) begin
                    next_state = S_MEMWR;
                    we_d       = 1'b1;
                    ld_wdata   = 1'b1;
                end else begin
                    next_state = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (mem_ready) next_state = S_MEMWB;
                else           req_d = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else begin
                    req_d = 1'b1;
                    we_d  = 1'b1;
                end
            end
            S_EXEC:   next_state = funct_ok ? S_ALUWB : S_HALT;
            S_ADDI:   next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB: next_state = S_FETCH;
            S_BRANCH: begin
                // pc already points past the branch
                if ((a == b) ^ (opcode == OP_BNE)) pc_d = pc + (sign_imm << 2);
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_d       = {pc[31:28], ir[25:0], 2'b00};
                next_state = S_FETCH;
            end
            default: next_state = S_HALT;
        endcase
        // Leaving an instruction's last state retires it and launches the next fetch.
        if (next_state == S_FETCH && state != S_FETCH) begin
            retire  = 1'b1;
            req_d   = 1'b1;
            we_d    = 1'b0;
            ld_addr = 1'b1;
            addr_d  = pc_d;
        end
    end

    // Datapath, register file and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            retired   <= '0;
            illegal   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            pc      <= pc_d;
            mem_req <= req_d;
            mem_we  <= we_d;
            if (ld_addr)  mem_addr  <= addr_d[ADDR_W-1:0];
            if (ld_wdata) mem_wdata <= b;
            if (retire)   retired   <= retired + CNT_W'(1);
            if (next_state == S_HALT && state != S_HALT) illegal <= 1'b1;
            case (state)
                S_FETCH:          if (mem_req && mem_ready) ir <= mem_rdata;
                S_DECODE: begin
                    a <= rf[rs];
                    b <= rf[rt];
                end
                S_MEMADR, S_ADDI: alu_out <= alu_sum;
                S_EXEC:           alu_out <= alu_r;
                S_MEMRD:          if (mem_ready) mdr <= mem_rdata;
                S_MEMWB:          if (rt != 5'd0) rf[rt] <= mdr;
                S_ALUWB:          if (rd != 5'd0) rf[rd] <= alu_out;
                S_ADDIWB:         if (rt != 5'd0) rf[rt] <= alu_out;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed instruction table,
// multi-cycle handshake sequences and random programs against an ISA model.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory image loaded while reset is high; bench memory and its write log
    logic [31:0] img [64];
    logic [31:0] mem [64];
    logic [31:0] m_mem [64];
    logic [31:0] m_reg [32];
    int          wr_cnt;
    logic [31:0] wr_addr, wr_data;

    int   ready_mode = 0;      // 0: always ready, 1: random, 2: ready_man
    logic ready_man  = 1'b1;
    logic rnd_ready  = 1'b1;

    logic [31:0] fa [16];
    int          ft [16];
    int          nf;

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign mem_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rnd_ready : ready_man;
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(negedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
            wr_cnt <= 0;
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance to the first negedge with a request outstanding
    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) return;
        end
        check("wait_req_timeout", 32'd0, 32'd1);
    endtask

    // Cycles from the current (first request) cycle until retired reaches target
    task automatic count_to_retire(input logic [31:0] target, output int n);
        n = -1;
        for (int i = 1; i < 400; i++) begin
            if (retired == target) begin
                n = i - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic collect_fetches(input int ncyc);
        logic prev;
        prev = 1'b0;
        nf   = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (mem_req && !prev && nf < 16) begin
                fa[nf] = mem_addr;
                ft[nf] = c;
                nf++;
            end
            prev = mem_req;
        end
    endtask

    // Instruction-level interpreter of the supported ISA
    task automatic model_run(output int steps, output logic [31:0] mpc);
        logic [31:0] ins, pcv, av, bv, simm, ea;
        int  rs, rt, rd;
        bit  done;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        pcv = 32'd0; steps = 0; done = 0;
        while (!done && steps < 500) begin
            ins  = m_mem[pcv[7:2]];
            pcv  = pcv + 32'd4;
            rs   = int'(ins[25:21]);
            rt   = int'(ins[20:16]);
            rd   = int'(ins[15:11]);
            av   = m_reg[rs];
            bv   = m_reg[rt];
            simm = {{16{ins[15]}}, ins[15:0]};
            ea   = av + simm;
            case (ins[31:26])
                6'h00: begin
                    case (ins[5:0])
                        6'h20: if (rd != 0) m_reg[rd] = av + bv;
                        6'h22: if (rd != 0) m_reg[rd] = av - bv;
                        6'h24: if (rd != 0) m_reg[rd] = av & bv;
                        6'h25: if (rd != 0) m_reg[rd] = av | bv;
                        6'h2A: if (rd != 0) m_reg[rd] = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                        default: done = 1;
                    endcase
                end
                6'h23: if (rt != 0) m_reg[rt] = m_mem[ea[7:2]];
                6'h2B: m_mem[ea[7:2]] = bv;
                6'h04: if (av == bv) pcv = pcv + simm * 4;
                6'h05: if (av != bv) pcv = pcv + simm * 4;
                6'h08: if (rt != 0) m_reg[rt] = av + simm;
                6'h02: pcv = {pcv[31:28], ins[25:0], 2'b00};
                default: done = 1;
            endcase
            if (!done) steps++;
        end
        mpc = pcv;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        logic [31:0] r;
        int          k;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        k  = $urandom_range(0, 5);
        case ($urandom_range(0, 4))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            3:       fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        case (k)
            1: r = {6'h00, rs, rt, rd, 5'd0, fn};
            2: r = {6'h23, 5'd0, rt, 16'(32'h80 + 4 * $urandom_range(0, 15))};
            3: r = {6'h2B, 5'd0, rt, 16'(32'h80 + 4 * $urandom_range(0, 15))};
            4: r = {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, 16'd1};
            default: r = {6'h08, rs, rt, 16'($urandom)};
        endcase
        return r;
    endfunction

    task automatic run_random(input int idx);
        int          steps;
        logic [31:0] mpc;
        bit          halted;
        clear_img();
        for (int i = 0; i < 20; i++) img[i] = rand_instr();
        for (int k = 0; k < 7; k++) img[20 + k] = {6'h2B, 5'd0, 5'(k + 1), 16'(32'hC0 + 4 * k)};
        img[27] = 32'hFC00_0000;
        for (int i = 32; i < 64; i++) img[i] = $urandom;
        for (int i = 0; i < 64; i++) m_mem[i] = img[i];
        model_run(steps, mpc);
        ready_mode = 1;
        do_reset();
        halted = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (illegal) begin
                halted = 1;
                break;
            end
        end
        check($sformatf("rnd%0d_halt", idx), 32'(halted), 32'd1);
        @(negedge clk);
        check($sformatf("rnd%0d_retired", idx), retired, 32'(steps));
        check($sformatf("rnd%0d_pc", idx), pc, mpc);
        check($sformatf("rnd%0d_req_idle", idx), 32'(mem_req), 32'd0);
        for (int i = 32; i < 64; i++) check($sformatf("rnd%0d_mem%0d", idx, i), mem[i], m_mem[i]);
    endtask

    typedef struct {
        logic [31:0] instr;
        int          cycles;
        logic [31:0] pc_after;
        logic        ill;
    } vec_t;

    initial begin
        vec_t vecs [10];
        int   n;

        vecs[0] = '{32'h2001_0005, 4, 32'h0000_0004, 1'b0};  // addi $1,$0,5
        vecs[1] = '{32'h0022_1820, 4, 32'h0000_0004, 1'b0};  // add $3,$1,$2
        vecs[2] = '{32'h0022_182A, 4, 32'h0000_0004, 1'b0};  // slt $3,$1,$2
        vecs[3] = '{32'h8C02_0008, 5, 32'h0000_0004, 1'b0};  // lw $2,8($0)
        vecs[4] = '{32'hAC02_000C, 4, 32'h0000_0004, 1'b0};  // sw $2,12($0)
        vecs[5] = '{32'h1000_0002, 3, 32'h0000_000C, 1'b0};  // beq $0,$0,+2
        vecs[6] = '{32'h1400_0002, 3, 32'h0000_0004, 1'b0};  // bne $0,$0,+2
        vecs[7] = '{32'h0800_0040, 3, 32'h0000_0100, 1'b0};  // j 0x40
        vecs[8] = '{32'hFC00_0000, 0, 32'h0000_0004, 1'b1};  // opcode 3F
        vecs[9] = '{32'h0000_003F, 0, 32'h0000_0004, 1'b1};  // funct 3F

        clear_img();
        ready_mode = 0;
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // Directed single-instruction table
        for (int v = 0; v < 10; v++) begin
            clear_img();
            img[0] = vecs[v].instr;
            do_reset();
            wait_req();
            if (vecs[v].ill) begin
                repeat (8) @(negedge clk);
                check($sformatf("vec%0d_illegal", v), 32'(illegal), 32'd1);
                check($sformatf("vec%0d_req", v), 32'(mem_req), 32'd0);
                check($sformatf("vec%0d_retired", v), retired, 32'd0);
                check($sformatf("vec%0d_pc", v), pc, vecs[v].pc_after);
            end else begin
                count_to_retire(32'd1, n);
                check($sformatf("vec%0d_cycles", v), 32'(n), 32'(vecs[v].cycles));
                check($sformatf("vec%0d_pc", v), pc, vecs[v].pc_after);
                check($sformatf("vec%0d_fetch_addr", v), mem_addr, vecs[v].pc_after);
                check($sformatf("vec%0d_fetch_req", v), 32'(mem_req & ~mem_we), 32'd1);
            end
        end

        // Fetch wait states: request held stable, instruction finishes 3 cycles late
        clear_img();
        img[0] = 32'h2001_0005;
        img[1] = 32'hAC01_0080;
        img[2] = 32'hFC00_0000;
        ready_mode = 2;
        ready_man  = 1'b0;
        do_reset();
        wait_req();
        n = -1;
        for (int i = 1; i < 40; i++) begin
            if (retired == 32'd1) begin
                n = i - 1;
                break;
            end
            if (i <= 4) begin
                check($sformatf("ws_req_c%0d", i), 32'(mem_req), 32'd1);
                check($sformatf("ws_addr_c%0d", i), mem_addr, 32'd0);
            end
            if (i == 4) ready_man = 1'b1;
            @(negedge clk);
        end
        check("ws_cycles", 32'(n), 32'd7);
        check("ws_pc", pc, 32'd4);
        count_to_retire(32'd2, n);
        check("ws_sw_addr", wr_addr, 32'h80);
        check("ws_sw_data", wr_data, 32'd5);

        // lw then sw through a register
        clear_img();
        img[0] = 32'h8C02_0008;
        img[1] = 32'hAC02_000C;
        img[2] = 32'hDEAD_BEEF;
        ready_mode = 0;
        do_reset();
        wait_req();
        count_to_retire(32'd2, n);
        check("lwsw_cycles", 32'(n), 32'd9);
        check("lwsw_wr_cnt", 32'(wr_cnt), 32'd1);
        check("lwsw_wr_addr", wr_addr, 32'd12);
        check("lwsw_wr_data", wr_data, 32'hDEAD_BEEF);
        repeat (6) @(negedge clk);
        check("lwsw_halt_on_data", 32'(illegal), 32'd1);

        // beq loop back to itself
        clear_img();
        img[0] = 32'h0800_0002;
        img[2] = 32'h1000_FFFF;
        do_reset();
        collect_fetches(20);
        check("beq_nfetch", 32'(nf >= 4), 32'd1);
        if (nf >= 4) begin
            check("beq_f1", fa[1], 32'd8);
            check("beq_f2", fa[2], 32'd8);
            check("beq_f3", fa[3], 32'd8);
            check("beq_period1", 32'(ft[2] - ft[1]), 32'd3);
            check("beq_period2", 32'(ft[3] - ft[2]), 32'd3);
        end

        // bne falls through
        clear_img();
        img[0] = 32'h0800_0002;
        img[2] = 32'h1400_FFFF;
        img[3] = 32'hFC00_0000;
        do_reset();
        collect_fetches(12);
        check("bne_nfetch", 32'(nf >= 3), 32'd1);
        if (nf >= 3) check("bne_f2", fa[2], 32'd12);

        // Reset asserted during a store wait state
        clear_img();
        img[0] = 32'h2001_0007;
        img[1] = 32'hAC01_0080;
        ready_mode = 2;
        ready_man  = 1'b1;
        do_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                n = 1;
                break;
            end
        end
        check("rsw_store_seen", 32'(n), 32'd1);
        ready_man = 1'b0;
        check("rsw_retired_before", retired, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("rsw_req_waiting", 32'(mem_req & mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rsw_req_dropped", 32'(mem_req), 32'd0);
        check("rsw_pc", pc, 32'd0);
        check("rsw_retired", retired, 32'd0);
        check("rsw_no_write", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ready_man = 1'b1;

        // Random programs with random wait states
        for (int p = 0; p < 3; p++) run_random(p);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
